button_event: RTL and testbench
===============================

# button_event

Press classifier sitting directly downstream of the debouncer: consumes its clean, glitch-free button level and turns it into single-cycle event pulses (press, release, short, long, double, auto-repeat) plus a long-hold level. It feeds the UI/control logic, which must never see raw levels or duplicate events. Pure single-clock logic; no synchronizer, because the input is already clean and synchronous to `clk_in`.

## Interface
- `LONG_CYCLES`, default 100_000_000: hold time, in cycles, that qualifies a press as long (1 s at 100 MHz).
- `GAP_CYCLES`, default 30_000_000: maximum release-to-second-press gap, in cycles, for a double press.
- `REPEAT_CYCLES`, default 20_000_000: auto-repeat period, in cycles, while a long press is held.
- `clk_in` input 1: system clock. One clock.
- `rst_n_in` input 1: reset, asynchronous, active-low.
- `clean_in` input 1: debounced button level, 1 = pressed.
- `press_out` output 1: 1-cycle pulse on each rising edge of `clean_in`.
- `release_out` output 1: 1-cycle pulse on each falling edge of `clean_in`.
- `short_out` output 1: 1-cycle pulse for a confirmed single short press.
- `long_out` output 1: 1-cycle pulse when a hold reaches `LONG_CYCLES`.
- `double_out` output 1: 1-cycle pulse on the second press of a double press.
- `repeat_out` output 1: 1-cycle pulse every `REPEAT_CYCLES` while a long press is held.
- `long_held_out` output 1: level, high while the FSM is in LONG.

## Operation
- Edge detect: register `prev` samples `clean_in`. rise = `clean_in & ~prev`; fall = `~clean_in & prev`.
- One shared counter `cnt`, width `$clog2(max(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES)+1)`. It is cleared on every state change and saturates, never wraps.
- FSM states and transitions:
  - IDLE: on rise, go to HELD.
  - HELD: `cnt`++. On fall, go to GAP. On `cnt == LONG_CYCLES-1` with no fall, pulse `long_out` and go to LONG.
  - LONG: `cnt`++. On `cnt == REPEAT_CYCLES-1`, pulse `repeat_out` and clear `cnt`. On fall, go to IDLE; no short is issued.
  - GAP: `cnt`++. On rise before `cnt == GAP_CYCLES-1`, pulse `double_out` and go to HELD2. On `cnt == GAP_CYCLES-1`, pulse `short_out` and go to IDLE.
  - HELD2: no long or repeat detection. On fall, go to IDLE.
- Simultaneous events:
  - Fall on the same edge as the long threshold: fall wins. Go to GAP; no `long_out`.
  - Rise on the same edge as the GAP expiry: `short_out` and `press_out` pulse together, and the next state is HELD, which starts a new sequence. No `double_out`.
- `press_out` and `release_out` pulse on every edge in every state, independent of classification.
- Parameters must each be ≥ 2; this is checked by an elaboration-time assertion.

## Timing
- All outputs are registered.
- Reset (async assert, sync deassert handled upstream): state IDLE, `cnt` = 0, `prev` = 0, all outputs 0.
- Because `prev` resets to 0, a button held through reset produces `press_out` on the first edge after release. This is intentional.
- Reset asserted mid-sequence aborts it; no pending short, long or double is ever emitted.
- `clean_in` first sampled 1 at edge P: `press_out` is high for edge P to P+1. Latency is 1 cycle from the sampling edge.
- Held through edge P+LONG_CYCLES-1, with no fall there: `long_out` pulses at edge P+LONG_CYCLES-1.
- Repeats pulse at edge P+LONG_CYCLES-1 + k·REPEAT_CYCLES, for k ≥ 1.
- Release sampled at edge R: `release_out` pulses at R. `short_out` pulses at R+GAP_CYCLES-1 unless a rise occurs first.
- `long_held_out` rises with `long_out` and falls with `release_out`.
- At most one classification pulse (`short_out`, `long_out` or `double_out`) per press.

## Structure
- Package `button_event_pkg`:
  - `state_t` enum {IDLE, HELD, LONG, GAP, HELD2}.
  - Default parameter constants.
  - A `max3` function used for the counter width.
- Sub-module `edge_detect`: owns `prev` and produces the rise/fall strobes. It is reused by other input stages.
- FSM and counter live in `button_event`.

## Test plan
Bench parameters: LONG=20, GAP=8, REPEAT=5.
- Short press: rise at edge 10, fall at edge 15.
  - `press_out`@10, `release_out`@15, `short_out`@22.
  - No `long_out` or `double_out`.
- Double press: rise@10, fall@13, rise@17, fall@19.
  - `double_out`@17 only; no `short_out`.
  - State returns to IDLE @19.
- Long press with repeat: rise@10, held to 45.
  - `long_out`@29, `long_held_out` high 29–45.
  - `repeat_out`@34, 39, 44.
  - Fall@45 returns to IDLE; no `short_out`.
- Boundaries:
  - Fall exactly @29 after rise@10: no `long_out`, `short_out`@36.
  - Rise exactly on GAP expiry: `short_out` and `press_out` in the same cycle, no `double_out`, state HELD.
- Reset mid-GAP: rise@10, fall@13, `rst_n_in` low @16–18.
  - All outputs 0 immediately (async).
  - No `short_out` afterwards.
  - `clean_in` held 1 through reset gives `press_out` on the first edge after deassert.

Source files
------------

// File: rtl/button_event_pkg.sv
// button_event_pkg: shared types and constants for the button event classifier.
//   state_t          - classifier FSM states
//   DEF_*_CYCLES     - default timing parameters (100 MHz clock)
//   max3()           - largest of three values, used to size the shared counter
package button_event_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HELD  = 3'd1,
        LONG  = 3'd2,
        GAP   = 3'd3,
        HELD2 = 3'd4
    } state_t;

    localparam int DEF_LONG_CYCLES   = 100_000_000;
    localparam int DEF_GAP_CYCLES    = 30_000_000;
    localparam int DEF_REPEAT_CYCLES = 20_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_event_edge_detect.sv
// edge_detect: registers a clean synchronous level and flags its edges.
//   clk_in    - clock
//   rst_n_in  - asynchronous active-low reset (prev level clears to 0)
//   level_in  - clean level, already synchronous to clk_in
//   rise_out  - combinational strobe, level_in & ~prev
//   fall_out  - combinational strobe, ~level_in & prev
module edge_detect (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic level_in,
    output logic rise_out,
    output logic fall_out
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = level_in;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_out = level_in & ~prev_q;
    assign fall_out = ~level_in & prev_q;

endmodule

// File: rtl/button_event.sv
// button_event: turns a debounced button level into single-cycle events.
//   clk_in, rst_n_in - clock, asynchronous active-low reset
//   clean_in         - debounced level, 1 = pressed
//   press_out        - pulse on every rising edge of clean_in
//   release_out      - pulse on every falling edge of clean_in
//   short_out        - pulse once a single short press is confirmed
//   long_out         - pulse when a hold reaches LONG_CYCLES
//   double_out       - pulse on the second press of a double press
//   repeat_out       - pulse every REPEAT_CYCLES while a long press is held
//   long_held_out    - level, high while in LONG
//   state_out        - current FSM state (debug visibility)
// All outputs are registered.
module button_event
    import button_event_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic   clk_in,
    input  logic   rst_n_in,
    input  logic   clean_in,
    output logic   press_out,
    output logic   release_out,
    output logic   short_out,
    output logic   long_out,
    output logic   double_out,
    output logic   repeat_out,
    output logic   long_held_out,
    output state_t state_out
);

    localparam int CNT_W = $clog2(max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES) + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    if (LONG_CYCLES < 2 || GAP_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("button_event: LONG/GAP/REPEAT_CYCLES must each be >= 2");
    end

    logic rise;
    logic fall;

    edge_detect u_edge_detect (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .level_in (clean_in),
        .rise_out (rise),
        .fall_out (fall)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic press_q, press_d;
    logic release_q, release_d;
    logic short_q, short_d;
    logic long_q, long_d;
    logic double_q, double_d;
    logic repeat_q, repeat_d;
    logic long_held_q, long_held_d;

    // Saturating increment: a stuck counter is harmless, a wrapped one would
    // re-trigger thresholds.
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

    // Counter restarts on every state change. HELD and GAP load 1 because the
    // entry edge already counts as the first held/gap cycle, which puts long
    // at P+LONG_CYCLES-1 and short at R+GAP_CYCLES-1. LONG loads 0 so repeats
    // fall on whole REPEAT_CYCLES periods after long_out.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = rise;
        release_d = fall;
        short_d   = 1'b0;
        long_d    = 1'b0;
        double_d  = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = HELD;
                    cnt_d   = CNT_ONE;
                end
            end
            HELD: begin
                // A release on the threshold edge wins over long.
                if (fall) begin
                    state_d = GAP;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            LONG: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            GAP: begin
                // On expiry the short is confirmed; a coincident press opens
                // a fresh sequence instead of counting as a double.
                if (cnt_q == GAP_LAST) begin
                    short_d = 1'b1;
                    if (rise) begin
                        state_d = HELD;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (rise) begin
                    double_d = 1'b1;
                    state_d  = HELD2;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD2: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        long_held_d = (state_d == LONG);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            double_q    <= 1'b0;
            repeat_q    <= 1'b0;
            long_held_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press_q     <= press_d;
            release_q   <= release_d;
            short_q     <= short_d;
            long_q      <= long_d;
            double_q    <= double_d;
            repeat_q    <= repeat_d;
            long_held_q <= long_held_d;
        end
    end

    assign press_out     = press_q;
    assign release_out   = release_q;
    assign short_out     = short_q;
    assign long_out      = long_q;
    assign double_out    = double_q;
    assign repeat_out    = repeat_q;
    assign long_held_out = long_held_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed scenarios for button_event with LONG=20, GAP=8,
// REPEAT=5. Stimulus pushes {edge, output vector} records into exp_q; the
// monitor pops one record each time the DUT shows a pulse or a long_held change.
module tb_button_event;
    import button_event_pkg::*;

    localparam int LONG_C = 20;
    localparam int GAP_C  = 8;
    localparam int REP_C  = 5;
    localparam int W      = 39;

    // Output vector bit order: press, release, short, long, double, repeat, held
    localparam logic [6:0] V_PRESS = 7'b1000000;
    localparam logic [6:0] V_REL   = 7'b0100000;
    localparam logic [6:0] V_SHORT = 7'b0010000;
    localparam logic [6:0] V_LONG  = 7'b0001000;
    localparam logic [6:0] V_DBL   = 7'b0000100;
    localparam logic [6:0] V_REP   = 7'b0000010;
    localparam logic [6:0] V_HELD  = 7'b0000001;

    logic   clk_in;
    logic   rst_n_in;
    logic   clean_in;
    logic   press_out, release_out, short_out, long_out;
    logic   double_out, repeat_out, long_held_out;
    state_t state_out;

    logic [W-1:0] exp_q[$];
    int tests_run;
    int tests_failed;
    int edge_n;
    int base;
    logic held_prev;

    button_event #(
        .LONG_CYCLES   (LONG_C),
        .GAP_CYCLES    (GAP_C),
        .REPEAT_CYCLES (REP_C)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .clean_in      (clean_in),
        .press_out     (press_out),
        .release_out   (release_out),
        .short_out     (short_out),
        .long_out      (long_out),
        .double_out    (double_out),
        .repeat_out    (repeat_out),
        .long_held_out (long_held_out),
        .state_out     (state_out)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial edge_n = 0;
    always @(posedge clk_in) edge_n <= edge_n + 1;

    function automatic logic [6:0] out_vec();
        return {press_out, release_out, short_out, long_out,
                double_out, repeat_out, long_held_out};
    endfunction

    // ---------------- check / driver tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, req, edge_n);
        end
    endtask

    task automatic push(input int rel, input logic [6:0] v);
        exp_q.push_back({32'(base + rel), v});
    endtask

    // Returns at the falling edge that follows posedge number base+rel.
    task automatic wait_edge(input int rel);
        while (edge_n < base + rel) @(negedge clk_in);
    endtask

    // clean_in takes value v so that it is first sampled at edge base+rel.
    task automatic drive(input int rel, input logic v);
        wait_edge(rel - 1);
        clean_in = v;
    endtask

    task automatic start_scenario();
        @(negedge clk_in);
        base = edge_n;
    endtask

    task automatic end_scenario(input string name, input int rel_end);
        wait_edge(rel_end);
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_in) begin
        logic [6:0]   v;
        logic [W-1:0] got;
        if (!rst_n_in) begin
            held_prev = 1'b0;
        end else begin
            v = out_vec();
            if ((v[6:1] != 6'd0) || (v[0] != held_prev)) begin
                got = {32'(edge_n), v};
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 64'(got), 64'd0);
                end else begin
                    check("event", 64'(got), 64'(exp_q.pop_front()));
                end
            end
            held_prev = v[0];
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        held_prev    = 1'b0;
        base         = 0;
        rst_n_in     = 1'b0;
        clean_in     = 1'b0;
        repeat (3) @(negedge clk_in);
        check("reset_outputs", 64'(out_vec()), 64'd0);
        check("reset_state", 64'(state_out), 64'(IDLE));
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // Short press: rise@10 fall@15 -> short@22
        start_scenario();
        push(10, V_PRESS); push(15, V_REL); push(22, V_SHORT);
        drive(10, 1'b1); drive(15, 1'b0);
        end_scenario("short_drain", 30);

        // Double press: rise@10 fall@13 rise@17 fall@19
        start_scenario();
        push(10, V_PRESS); push(13, V_REL); push(17, V_PRESS | V_DBL); push(19, V_REL);
        drive(10, 1'b1); drive(13, 1'b0); drive(17, 1'b1);
        wait_edge(17);
        check("double_state_held2", 64'(state_out), 64'(HELD2));
        drive(19, 1'b0);
        wait_edge(19);
        check("double_state_idle", 64'(state_out), 64'(IDLE));
        end_scenario("double_drain", 35);

        // Long press with repeats: rise@10, fall@45
        start_scenario();
        push(10, V_PRESS);
        push(29, V_LONG | V_HELD);
        push(34, V_REP | V_HELD);
        push(39, V_REP | V_HELD);
        push(44, V_REP | V_HELD);
        push(45, V_REL);
        drive(10, 1'b1);
        wait_edge(30);
        check("long_state", 64'(state_out), 64'(LONG));
        drive(45, 1'b0);
        wait_edge(45);
        check("long_release_idle", 64'(state_out), 64'(IDLE));
        end_scenario("long_drain", 60);

        // Fall on the long threshold edge: no long, short@36
        start_scenario();
        push(10, V_PRESS); push(29, V_REL); push(36, V_SHORT);
        drive(10, 1'b1); drive(29, 1'b0);
        wait_edge(29);
        check("fall_at_long_gap", 64'(state_out), 64'(GAP));
        end_scenario("fall_at_long_drain", 50);

        // Rise exactly on GAP expiry (edge 20): short+press, HELD, new sequence
        start_scenario();
        push(10, V_PRESS); push(13, V_REL); push(20, V_PRESS | V_SHORT);
        push(22, V_REL); push(29, V_SHORT);
        drive(10, 1'b1); drive(13, 1'b0); drive(20, 1'b1);
        wait_edge(20);
        check("gap_expiry_state", 64'(state_out), 64'(HELD));
        drive(22, 1'b0);
        end_scenario("gap_expiry_drain", 40);

        // Reset mid-GAP with the button pressed again during reset
        start_scenario();
        push(10, V_PRESS); push(13, V_REL);
        push(19, V_PRESS); push(25, V_REL); push(32, V_SHORT);
        drive(10, 1'b1); drive(13, 1'b0);
        drive(16, 1'b1);
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("async_reset_outputs", 64'(out_vec()), 64'd0);
        check("async_reset_state", 64'(state_out), 64'(IDLE));
        wait_edge(18);
        rst_n_in = 1'b1;
        wait_edge(19);
        check("after_reset_state", 64'(state_out), 64'(HELD));
        drive(25, 1'b0);
        end_scenario("reset_drain", 40);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        tests_failed++;
        $display("FAIL watchdog: simulation did not complete, edge %0d", edge_n);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

endmodule
